// File: rtl/im_loader.sv
// Boot-time program loader: receives length/bytes/checksum, writes the instruction
// memory from address 0, pads the tail with FILL_WORD and releases the core on success.
module im_loader #(
  parameter int unsigned MEMORY_BITS = 8,
  parameter int unsigned MEMORY_SIZE = 256,
  parameter logic [MEMORY_BITS-1:0] FILL_WORD = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [MEMORY_BITS-1:0]         in_data,
  output logic                           in_ready,
  output logic                           im_we,
  output logic [$clog2(MEMORY_SIZE)-1:0] im_addr,
  output logic [MEMORY_BITS-1:0]         im_data,
  output logic                           cpu_hold,
  output logic                           done,
  output logic                           error
);

  localparam int unsigned AW = $clog2(MEMORY_SIZE);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] SIZE_C = CW'(MEMORY_SIZE);
  localparam logic [CW-1:0] LAST_C = CW'(MEMORY_SIZE - 1);

  typedef enum logic [2:0] {
    S_LEN, S_DATA, S_CSUM, S_FILL, S_DONE, S_ERROR
  } state_t;

  state_t                 state;
  logic [CW-1:0]          n_len;
  logic [CW-1:0]          cnt;
  logic [MEMORY_BITS-1:0] sum;
  logic                   xfer;

  assign xfer = in_valid && in_ready;

  // Loader sequencer; all outputs registered, im_we defaults low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LEN;
      n_len    <= '0;
      cnt      <= '0;
      sum      <= '0;
      in_ready <= 1'b1;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      im_we <= 1'b0;
      case (state)
        S_LEN: begin
          if (xfer) begin
            // A zero length byte encodes a full-memory image.
            n_len <= (in_data == '0) ? SIZE_C : CW'(in_data);
            cnt   <= '0;
            sum   <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            im_we   <= 1'b1;
            im_addr <= cnt[AW-1:0];
            im_data <= in_data;
            sum     <= sum + in_data;
            cnt     <= cnt + CW'(1);
            if (cnt + CW'(1) == n_len) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == sum) begin
              state <= (n_len == SIZE_C) ? S_DONE : S_FILL;
            end else begin
              error <= 1'b1;
              state <= S_ERROR;
            end
          end
        end
        S_FILL: begin
          // cnt already equals N on entry, so padding continues from there.
          im_we   <= 1'b1;
          im_addr <= cnt[AW-1:0];
          im_data <= FILL_WORD;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST_C) state <= S_DONE;
        end
        S_DONE: begin
          in_ready <= 1'b0;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        S_ERROR: begin
          in_ready <= 1'b0;
          error    <= 1'b1;
          cpu_hold <= 1'b1;
        end
        default: state <= S_LEN;
      endcase
    end
  end

endmodule
